// File: rtl/mc_port_sched.sv
// Round-robin scheduler sharing one memory-controller port among NUM_CORE cores,
// with a one-entry holding register, an outstanding-request credit limit and response steering.
module mc_port_sched #(
    parameter int NUM_CORE        = 16,
    parameter int NB_COREID       = 4,
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int MAX_OUTST       = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CORE-1:0]          core_rq_vld,
    input  logic [3*NUM_CORE-1:0]        core_rq_cmd,
    input  logic [48*NUM_CORE-1:0]       core_rq_vadr,
    input  logic [64*NUM_CORE-1:0]       core_rq_data,
    output logic [NUM_CORE-1:0]          core_rq_ack,
    output logic                         mc_rq_vld,
    output logic [2:0]                   mc_rq_cmd,
    output logic [3:0]                   mc_rq_scmd,
    output logic [47:0]                  mc_rq_vadr,
    output logic [1:0]                   mc_rq_size,
    output logic [MC_RTNCTL_WIDTH-1:0]   mc_rq_rtnctl,
    output logic [63:0]                  mc_rq_data,
    output logic                         mc_rq_flush,
    input  logic                         mc_rq_stall,
    input  logic                         mc_rs_vld,
    input  logic [MC_RTNCTL_WIDTH-1:0]   mc_rs_rtnctl,
    input  logic [63:0]                  mc_rs_data,
    output logic                         mc_rs_stall,
    output logic [NUM_CORE-1:0]          core_rs_vld,
    output logic [63:0]                  core_rs_data,
    output logic [7:0]                   outst_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                 state, state_nxt;
    logic [NB_COREID-1:0]   last_gnt, winner, rs_id;
    logic [NB_COREID:0]     rr_sum;
    logic                   found, issue, load, cnt_dec;
    logic [8:0]             credit_sum;
    logic                   unused_rtnctl;

    assign mc_rq_scmd  = 4'd0;
    assign mc_rq_size  = 2'd3;
    assign mc_rq_flush = 1'b0;
    assign mc_rs_stall = 1'b0;

    assign mc_rq_vld  = (state == FULL);
    assign issue      = mc_rq_vld & ~mc_rq_stall;
    assign credit_sum = {1'b0, outst_cnt} + {8'd0, issue};
    assign load       = (state == EMPTY || issue) && (|core_rq_vld)
                        && (credit_sum < 9'(MAX_OUTST));

    // Search starts just past the previous grant so every core gets a turn.
    always_comb begin
        winner = last_gnt;
        found  = 1'b0;
        rr_sum = '0;
        for (int i = 1; i <= NUM_CORE; i++) begin
            rr_sum = {1'b0, last_gnt} + (NB_COREID+1)'(i);
            if (rr_sum >= (NB_COREID+1)'(NUM_CORE))
                rr_sum = rr_sum - (NB_COREID+1)'(NUM_CORE);
            if (!found && core_rq_vld[rr_sum[NB_COREID-1:0]]) begin
                winner = rr_sum[NB_COREID-1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        core_rq_ack = '0;
        if (load && rst_n)
            core_rq_ack[winner] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        if (load)
            state_nxt = FULL;
        else if (issue)
            state_nxt = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= EMPTY;
            last_gnt     <= NB_COREID'(NUM_CORE-1);
            mc_rq_cmd    <= '0;
            mc_rq_vadr   <= '0;
            mc_rq_data   <= '0;
            mc_rq_rtnctl <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                last_gnt     <= winner;
                mc_rq_cmd    <= core_rq_cmd[3*winner +: 3];
                mc_rq_vadr   <= core_rq_vadr[48*winner +: 48];
                mc_rq_data   <= core_rq_data[64*winner +: 64];
                mc_rq_rtnctl <= {{(MC_RTNCTL_WIDTH-NB_COREID){1'b0}}, winner};
            end
        end
    end

    // A response arriving with nothing outstanding is dropped so the count never wraps.
    assign cnt_dec = mc_rs_vld && (outst_cnt != 8'd0);

    always_ff @(posedge clk) begin
        if (!rst_n)
            outst_cnt <= '0;
        else if (issue && !mc_rs_vld)
            outst_cnt <= outst_cnt + 8'd1;
        else if (cnt_dec && !issue)
            outst_cnt <= outst_cnt - 8'd1;
    end

    assign rs_id         = mc_rs_rtnctl[NB_COREID-1:0];
    assign unused_rtnctl = ^mc_rs_rtnctl[MC_RTNCTL_WIDTH-1:NB_COREID];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_rs_vld  <= '0;
            core_rs_data <= '0;
        end else begin
            core_rs_vld <= '0;
            if (mc_rs_vld && ({1'b0, rs_id} < (NB_COREID+1)'(NUM_CORE)))
                core_rs_vld[rs_id] <= 1'b1;
            if (mc_rs_vld)
                core_rs_data <= mc_rs_data;
        end
    end

endmodule

// File: doc/mc_port_sched.md
# mc_port_sched

Shares the single Convey memory-controller port among the `NUM_CORE` phold cores. It is a round-robin request scheduler with a one-entry output holding register, so a stalled port never loses a request. It applies an outstanding-request credit limit and steers each response back to the issuing core using the core ID carried in `rtnctl`. It replaces the per-core mux/arbiter glue between the phold cores and the top-level `mc_*` pins.

## Interface
- `NUM_CORE`, 16 — number of requesting cores
- `NB_COREID`, 4 — core ID width; `2**NB_COREID >= NUM_CORE`
- `MC_RTNCTL_WIDTH`, 32 — width of the rtnctl field
- `MAX_OUTST`, 8 — maximum issued-but-unreturned requests (1..255)
- `clk` in 1 — clock
- `rst_n` in 1 — reset, synchronous, active-low
- `core_rq_vld` in NUM_CORE — per-core request valid; held until accepted
- `core_rq_cmd` in 3*NUM_CORE — packed commands; core g at `[3g +: 3]`
- `core_rq_vadr` in 48*NUM_CORE — packed addresses
- `core_rq_data` in 64*NUM_CORE — packed store data
- `core_rq_ack` out NUM_CORE — one-hot pulse; request of that core latched this cycle
- `mc_rq_vld` out 1 — request to the memory controller
- `mc_rq_cmd` out 3
- `mc_rq_scmd` out 4 — constant 0
- `mc_rq_vadr` out 48
- `mc_rq_size` out 2 — constant 2'd3 (8 bytes)
- `mc_rq_rtnctl` out MC_RTNCTL_WIDTH — `{zeros, core_id}`
- `mc_rq_data` out 64
- `mc_rq_flush` out 1 — constant 0
- `mc_rq_stall` in 1 — controller back-pressure
- `mc_rs_vld` in 1
- `mc_rs_rtnctl` in MC_RTNCTL_WIDTH
- `mc_rs_data` in 64
- `mc_rs_stall` out 1 — constant 0
- `core_rs_vld` out NUM_CORE — one-hot response valid
- `core_rs_data` out 64 — response data, shared by all cores
- `outst_cnt` out 8 — current outstanding count

## Operation
- **States**
  - EMPTY: holding register free.
  - FULL: holding register occupied; `mc_rq_vld` = 1.
- **Issue.** `issue = mc_rq_vld & ~mc_rq_stall`.
- **Load.** `load` = (EMPTY, or FULL with `issue`) and any `core_rq_vld` and `outst_cnt + issue < MAX_OUTST`.
- **Arbitration**
  - Round-robin over `core_rq_vld`.
  - Search starts at `last_gnt+1` mod `NUM_CORE`.
  - `last_gnt` updates only on `load`. Reset value is `NUM_CORE-1`, so core 0 has first priority.
- **On `load`**
  - `core_rq_ack[winner]` = 1, combinational in the same cycle.
  - cmd/vadr/data of the winner are latched; rtnctl is latched as `winner` zero-extended.
  - Next state is FULL.
- **Issue without a load:** FULL → EMPTY.
- **Hold under stall:** in FULL with stall, all `mc_rq_*` fields stay stable.
- **Outstanding counter**
  - +1 on `issue`, −1 on `mc_rs_vld`.
  - Both in the same cycle: unchanged.
  - Never wraps. `mc_rs_vld` at count 0 is ignored; the counter saturates at 0.
- **Response routing**
  - `id = mc_rs_rtnctl[NB_COREID-1:0]`.
  - Registered: `core_rs_vld` <= one-hot(id) when `mc_rs_vld`, else 0.
  - `core_rs_data` <= `mc_rs_data` on `mc_rs_vld`, held otherwise.
  - An `id >= NUM_CORE` produces no `core_rs_vld`.

## Timing
- **Reset.** With `rst_n` = 0 at a `clk` edge:
  - State goes to EMPTY.
  - `mc_rq_vld`, `core_rs_vld`, `outst_cnt`, `mc_rq_cmd/vadr/data/rtnctl` and `core_rs_data` go to 0.
  - `core_rq_ack` is forced to 0 while `rst_n` is low.
  - A reset mid-operation drops the held request and clears all credits.
- **Request latency:** ack in cycle t, `mc_rq_vld` from t+1.
- **Back-to-back issue.** A FULL register with `issue` reloads in the same cycle, giving one request per cycle.
- **Response latency:** `mc_rs_vld` in cycle t → `core_rs_vld` in t+1.
- **Credit limit.** At `outst_cnt == MAX_OUTST` no `load` occurs. An `issue` that brings the count to `MAX_OUTST` blocks a same-cycle reload. A response in cycle t permits a load in t+1.
- **Outputs.** `mc_rs_stall`, `mc_rq_flush` and `mc_rq_scmd` are always 0.

## Test plan
- **Round-robin order.** After reset, hold `core_rq_vld` = 16'hFFFF with no stall and no credit limit. → Acks go to cores 0,1,…,15,0 on consecutive cycles. `mc_rq_rtnctl` matches each with a one-cycle lag.
- **Stall hold.** Core 5 requests vadr 48'h1000; `mc_rq_stall` = 1 for 4 cycles. → `mc_rq_vld`/vadr are held for 4 cycles and issue on the 5th. Core 5 gets exactly one ack.
- **Credit limit.** `MAX_OUTST` = 8, all cores requesting, no responses. → Exactly 8 issues, then `outst_cnt` = 8 and no acks. One `mc_rs_vld` → next cycle a new ack, count back to 8 after issue.
- **Response routing.** `mc_rs_vld` with rtnctl 3, data 64'hDEAD_BEEF. → Next cycle `core_rs_vld` = 16'h0008 and `core_rs_data` = 64'hDEAD_BEEF. With rtnctl 3 and a simultaneous issue, `outst_cnt` is unchanged.
- **Mid-operation reset.** Assert `rst_n` = 0 in FULL with count 5. → Next edge: `mc_rq_vld` = 0, `outst_cnt` = 0. The first post-reset grant goes to core 0.
